// File: rtl/wrr_prio_update_ctrl_if.sv
// Priority-update bus between the config/sweep master and wrr_prio_update_ctrl.
// Carries the single-write handshake, the bulk controls, the shadow read port and the arbiter update port.
interface wrr_prio_update_ctrl_if #(
  parameter int N          = 32,
  parameter int PRIORITY_W = 4,
  parameter int ID_BITS    = $clog2(N)
);
  logic                  cfg_valid;
  logic                  cfg_ready;
  logic [ID_BITS-1:0]    cfg_id;
  logic [PRIORITY_W-1:0] cfg_prio;
  logic                  bulk_start;
  logic [PRIORITY_W-1:0] bulk_prio;
  logic                  bulk_busy;
  logic                  bulk_done;
  logic [ID_BITS-1:0]    rd_id;
  logic [PRIORITY_W-1:0] rd_prio;
  logic [PRIORITY_W-1:0] prio;
  logic [ID_BITS-1:0]    prio_id;
  logic                  prio_upt;

  modport master (
    output cfg_valid, cfg_id, cfg_prio, bulk_start, bulk_prio, rd_id,
    input  cfg_ready, bulk_busy, bulk_done, rd_prio, prio, prio_id, prio_upt
  );

  modport slave (
    input  cfg_valid, cfg_id, cfg_prio, bulk_start, bulk_prio, rd_id,
    output cfg_ready, bulk_busy, bulk_done, rd_prio, prio, prio_id, prio_upt
  );
endinterface

// File: rtl/wrr_prio_update_ctrl.sv
// Serialises init/bulk sweeps and single config writes onto the WRR arbiter's priority-update port.
// Optional WRR_PRIO_UPD_SKIP_SAME_EN: single writes that do not change the shadow value issue no update.
module wrr_prio_update_ctrl #(
  parameter int N            = 32,
  parameter int PRIORITY_W   = 4,
  parameter int ID_BITS      = $clog2(N),
  parameter int DEFAULT_PRIO = 1,
  parameter int GAP          = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  wrr_prio_update_ctrl_if.slave   bus
);
  localparam int                   IDX_W   = $clog2(N + 1);
  localparam logic [IDX_W-1:0]     IDX_END = IDX_W'(N);
  localparam logic [PRIORITY_W-1:0] DEF_P  = PRIORITY_W'(DEFAULT_PRIO);

  typedef enum logic {SWEEP, IDLE} state_t;

  state_t                state_q, state_n;
  logic [IDX_W-1:0]      idx_q, idx_n;
  logic [PRIORITY_W-1:0] sweep_val_q, sweep_val_n;
  logic [3:0]            gap_q, gap_n;
  logic [PRIORITY_W-1:0] shadow [N];

  logic [PRIORITY_W-1:0] prio_q, prio_n;
  logic [ID_BITS-1:0]    prio_id_q, prio_id_n;
  logic                  upt_q, busy_q, busy_n, done_q, done_n;

  logic                  issue;
  logic [ID_BITS-1:0]    issue_id;
  logic [PRIORITY_W-1:0] issue_val;
  logic                  cfg_rdy, cfg_in_range, cfg_same, cfg_write;

  assign cfg_in_range = int'(bus.cfg_id) < N;
  assign cfg_same     = cfg_in_range && (shadow[bus.cfg_id] == bus.cfg_prio);
`ifdef WRR_PRIO_UPD_SKIP_SAME_EN
  assign cfg_write    = cfg_in_range && !cfg_same;
`else
  assign cfg_write    = cfg_in_range;
`endif

  // NOTE: every signal driven here gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_n     = state_q;
    idx_n       = idx_q;
    sweep_val_n = sweep_val_q;
    gap_n       = (gap_q != 4'd0) ? gap_q - 4'd1 : 4'd0;
    issue       = 1'b0;
    issue_id    = '0;
    issue_val   = '0;
    cfg_rdy     = 1'b0;
    prio_n      = prio_q;
    prio_id_n   = prio_id_q;

    unique case (state_q)
      SWEEP: begin
        if (gap_q == 4'd0) begin
          if (idx_q != IDX_END) begin
            issue     = 1'b1;
            issue_id  = idx_q[ID_BITS-1:0];
            issue_val = sweep_val_q;
            idx_n     = idx_q + IDX_W'(1);
          end else begin
            state_n = IDLE;
          end
        end
      end
      IDLE: begin
        cfg_rdy = !rst && (gap_q == 4'd0) && !bus.bulk_start;
        // A bulk issues id 0 in its acceptance cycle; the remaining ids follow in SWEEP.
        if ((gap_q == 4'd0) && bus.bulk_start) begin
          issue       = 1'b1;
          issue_id    = '0;
          issue_val   = bus.bulk_prio;
          sweep_val_n = bus.bulk_prio;
          idx_n       = IDX_W'(1);
          state_n     = SWEEP;
        end else if (bus.cfg_valid && cfg_rdy && cfg_write) begin
          issue     = 1'b1;
          issue_id  = bus.cfg_id;
          issue_val = bus.cfg_prio;
        end
      end
    endcase

    if (issue) begin
      prio_n    = issue_val;
      prio_id_n = issue_id;
      gap_n     = 4'(GAP);
    end
    done_n = issue && (state_n == SWEEP) && (idx_n == IDX_END);
    busy_n = (state_n == SWEEP) && (issue || (idx_n != IDX_END));
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= SWEEP;
      idx_q       <= '0;
      sweep_val_q <= DEF_P;
      gap_q       <= 4'd0;
      prio_q      <= '0;
      prio_id_q   <= '0;
      upt_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      // NOTE: the shadow must read DEFAULT_PRIO right after reset, so this memory is reset entry by entry.
      for (int i = 0; i < N; i++) shadow[i] <= DEF_P;
    end else begin
      state_q     <= state_n;
      idx_q       <= idx_n;
      sweep_val_q <= sweep_val_n;
      gap_q       <= gap_n;
      prio_q      <= prio_n;
      prio_id_q   <= prio_id_n;
      upt_q       <= issue;
      busy_q      <= busy_n;
      done_q      <= done_n;
      if (issue) shadow[issue_id] <= issue_val;
    end
  end

  assign bus.cfg_ready = cfg_rdy;
  assign bus.rd_prio   = (int'(bus.rd_id) < N) ? shadow[bus.rd_id] : '0;
  assign bus.prio      = prio_q;
  assign bus.prio_id   = prio_id_q;
  assign bus.prio_upt  = upt_q;
  assign bus.bulk_busy = busy_q;
  assign bus.bulk_done = done_q;
endmodule

// File: tb/tb_wrr_prio_update_ctrl.sv
// Bench for wrr_prio_update_ctrl: two instances (GAP=0 and GAP=2) share stimulus and are checked against
// a schedule model that computes update edges arithmetically from acceptance times.
module tb_wrr_prio_update_ctrl;
  localparam int N   = 32;
  localparam int PW  = 4;
  localparam int DEF = 1;
  localparam int G0  = 0;
  localparam int G1  = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          cfg_valid, bulk_start;
  logic [4:0]    cfg_id, rd_id;
  logic [PW-1:0] cfg_prio, bulk_prio;

  wrr_prio_update_ctrl_if #(.N(N), .PRIORITY_W(PW)) b0 ();
  wrr_prio_update_ctrl_if #(.N(N), .PRIORITY_W(PW)) b1 ();

  assign b0.cfg_valid = cfg_valid;  assign b1.cfg_valid = cfg_valid;
  assign b0.cfg_id    = cfg_id;     assign b1.cfg_id    = cfg_id;
  assign b0.cfg_prio  = cfg_prio;   assign b1.cfg_prio  = cfg_prio;
  assign b0.bulk_start = bulk_start; assign b1.bulk_start = bulk_start;
  assign b0.bulk_prio = bulk_prio;  assign b1.bulk_prio = bulk_prio;
  assign b0.rd_id     = rd_id;      assign b1.rd_id     = rd_id;

  wrr_prio_update_ctrl #(.N(N), .PRIORITY_W(PW), .DEFAULT_PRIO(DEF), .GAP(G0))
    dut0 (.clk(clk), .rst(rst), .bus(b0.slave));
  wrr_prio_update_ctrl #(.N(N), .PRIORITY_W(PW), .DEFAULT_PRIO(DEF), .GAP(G1))
    dut1 (.clk(clk), .rst(rst), .bus(b1.slave));

  logic          o_ready[2], o_upt[2], o_busy[2], o_done[2];
  logic [PW-1:0] o_rd[2], o_prio[2];
  logic [4:0]    o_id[2];
  assign o_ready[0] = b0.cfg_ready; assign o_ready[1] = b1.cfg_ready;
  assign o_upt[0]   = b0.prio_upt;  assign o_upt[1]   = b1.prio_upt;
  assign o_busy[0]  = b0.bulk_busy; assign o_busy[1]  = b1.bulk_busy;
  assign o_done[0]  = b0.bulk_done; assign o_done[1]  = b1.bulk_done;
  assign o_rd[0]    = b0.rd_prio;   assign o_rd[1]    = b1.rd_prio;
  assign o_prio[0]  = b0.prio;      assign o_prio[1]  = b1.prio;
  assign o_id[0]    = b0.prio_id;   assign o_id[1]    = b1.prio_id;

  // Reference model: sweeps are described by first/last issue edge; single writes by next_ok.
  int            gap_of[2];
  int            next_ok[2], sw_first[2], sw_last[2];
  bit            sw_on[2], init_pend[2];
  logic [PW-1:0] sw_val[2];
  logic [PW-1:0] sh[2][N];
  logic          e_upt[2], e_busy[2], e_done[2];
  logic [PW-1:0] e_prio[2];
  int            e_id[2];
  int            edge_n = 0;
  int            n_checks = 0;
  int            n_fails = 0;
  bit            known = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, edge_n);
    end
  endtask

  task automatic start_sweep(input int d, input int e, input logic [PW-1:0] v);
    sw_on[d]    = 1'b1;
    sw_first[d] = e;
    sw_last[d]  = e + (N - 1) * (gap_of[d] + 1);
    sw_val[d]   = v;
    next_ok[d]  = sw_last[d] + gap_of[d] + 2;
  endtask

  task automatic tick();
    int  e;
    bit  exp_ready, wr;
    int  k;
    string p;
    e = edge_n + 1;
    #1;
    for (int d = 0; d < 2; d++) begin
      p = $sformatf("g%0d.", gap_of[d]);
      if (known) check({p, "rd_prio"}, 32'(o_rd[d]), 32'(sh[d][rd_id]));
      if (rst) begin
        exp_ready    = 1'b0;
        e_upt[d]     = 1'b0;
        e_busy[d]    = 1'b0;
        e_done[d]    = 1'b0;
        e_prio[d]    = '0;
        e_id[d]      = 0;
        sw_on[d]     = 1'b0;
        init_pend[d] = 1'b1;
        next_ok[d]   = 1 << 30;
        for (int i = 0; i < N; i++) sh[d][i] = PW'(DEF);
      end else begin
        if (init_pend[d]) begin
          start_sweep(d, e, PW'(DEF));
          init_pend[d] = 1'b0;
        end
        exp_ready = (e >= next_ok[d]) && !bulk_start;
        if ((e >= next_ok[d]) && bulk_start) start_sweep(d, e, bulk_prio);
        e_upt[d]  = 1'b0;
        e_done[d] = 1'b0;
        if (sw_on[d] && e >= sw_first[d] && e <= sw_last[d] &&
            ((e - sw_first[d]) % (gap_of[d] + 1)) == 0) begin
          k         = (e - sw_first[d]) / (gap_of[d] + 1);
          e_upt[d]  = 1'b1;
          e_id[d]   = k;
          e_prio[d] = sw_val[d];
          e_done[d] = (e == sw_last[d]);
          sh[d][k]  = sw_val[d];
        end else if (exp_ready && cfg_valid) begin
          wr = int'(cfg_id) < N;
`ifdef WRR_PRIO_UPD_SKIP_SAME_EN
          if (sh[d][cfg_id] == cfg_prio) wr = 1'b0;
`endif
          if (wr) begin
            e_upt[d]       = 1'b1;
            e_id[d]        = int'(cfg_id);
            e_prio[d]      = cfg_prio;
            sh[d][cfg_id]  = cfg_prio;
            next_ok[d]     = e + gap_of[d] + 1;
          end
        end
        e_busy[d] = sw_on[d] && e >= sw_first[d] && e <= sw_last[d];
      end
      if (known) check({p, "cfg_ready"}, 32'(o_ready[d]), 32'(exp_ready));
    end
    @(posedge clk);
    edge_n++;
    if (rst) known = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      p = $sformatf("g%0d.", gap_of[d]);
      check({p, "prio_upt"},  32'(o_upt[d]),  32'(e_upt[d]));
      check({p, "prio"},      32'(o_prio[d]), 32'(e_prio[d]));
      check({p, "prio_id"},   32'(o_id[d]),   32'(e_id[d]));
      check({p, "bulk_busy"}, 32'(o_busy[d]), 32'(e_busy[d]));
      check({p, "bulk_done"}, 32'(o_done[d]), 32'(e_done[d]));
    end
  endtask

  initial begin
    gap_of[0] = G0;
    gap_of[1] = G1;
    for (int d = 0; d < 2; d++) begin
      next_ok[d] = 1 << 30; sw_on[d] = 1'b0; init_pend[d] = 1'b0;
      e_prio[d] = '0; e_id[d] = 0;
    end
    rst = 1'b1; cfg_valid = 1'b0; cfg_id = '0; cfg_prio = '0;
    bulk_start = 1'b0; bulk_prio = '0; rd_id = '0;
    @(negedge clk);
    repeat (3) tick();

    // Init sweep after reset release.
    rst = 1'b0;
    for (int i = 0; i < 110; i++) begin rd_id = 5'(i); tick(); end

    // Held single writes, then a write equal to the default value.
    cfg_valid = 1'b1; cfg_id = 5'd5; cfg_prio = 4'd9; rd_id = 5'd5;
    repeat (4) tick();
    cfg_id = 5'd7; cfg_prio = 4'd3;
    repeat (4) tick();
    cfg_valid = 1'b0;
    repeat (4) tick();
    cfg_valid = 1'b1; cfg_id = 5'd3; cfg_prio = 4'd1; rd_id = 5'd3;
    repeat (2) tick();
    cfg_valid = 1'b0;
    repeat (3) tick();

    // Bulk and cfg in the same cycle; cfg held until it wins after the sweep.
    bulk_start = 1'b1; bulk_prio = 4'd4; cfg_valid = 1'b1; cfg_id = 5'd9; cfg_prio = 4'd12;
    tick();
    bulk_start = 1'b0;
    for (int i = 0; i < 110; i++) begin rd_id = 5'(i); tick(); end
    cfg_valid = 1'b0;

    // Reset in the middle of a bulk sweep.
    bulk_start = 1'b1; bulk_prio = 4'd6;
    tick();
    bulk_start = 1'b0;
    repeat (10) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 110; i++) begin rd_id = 5'(i); tick(); end

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      rst        = ($urandom_range(0, 599) == 0);
      bulk_start = ($urandom_range(0, 149) == 0);
      bulk_prio  = 4'($urandom);
      cfg_valid  = 1'($urandom);
      cfg_id     = 5'($urandom);
      cfg_prio   = 4'($urandom);
      rd_id      = 5'($urandom);
      tick();
    end
    rst = 1'b0; bulk_start = 1'b0; cfg_valid = 1'b0;
    repeat (5) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
